// File: rtl/i2c_reg_table_cfg.sv
// I2C register-table configurator: walks a ROM of {sub,data} entries and
// writes each to DEV_ADDR with a built-in tick-driven bit engine.
// Ports: iCLK/iRST_N clock and async reset; tbl_addr/tbl_data ROM port;
//   start/int_n restart requests; scl_oe/sda_oe/sda_i open-drain bus;
//   busy/ready/error/err_idx status.
module i2c_reg_table_cfg #(
  parameter int          CLK_FREQ      = 50000000,
  parameter int          I2C_FREQ      = 100000,
  parameter logic [7:0]  DEV_ADDR      = 8'h72,
  parameter int          TBL_DEPTH     = 31,
  parameter int          TBL_AW        = 6,
  parameter int          MAX_RETRY     = 3,
  parameter int          REINIT_ON_INT = 1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  input  logic              start,
  input  logic              int_n,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic              sda_i,
  output logic              busy,
  output logic              ready,
  output logic              error,
  output logic [TBL_AW-1:0] err_idx
);

  localparam int TICK_RAW = CLK_FREQ / (4 * I2C_FREQ);
  localparam int TICK     = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int DW       = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_SHIFT,
    S_ACK, S_STOP, S_NEXT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [1:0]        ph_q, ph_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic [23:0]       sr_q, sr_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              nack_q, nack_d;
  logic              err_q, err_d;
  logic [TBL_AW-1:0] eidx_q, eidx_d;
  logic              ld_q, ld_d;
  logic              scl_q, scl_d;
  logic              sda_q, sda_d;
  logic              int_s1_q, int_s2_q;
  logic              sda_s1_q, sda_s2_q;
  logic              tick;
  logic              restart;

  assign tick    = (div_q == DW'(TICK - 1));
  assign restart = start | ((REINIT_ON_INT != 0) & ~int_s2_q);

  assign tbl_addr = idx_q;
  assign scl_oe   = scl_q;
  assign sda_oe   = sda_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign ready    = (state_q == S_DONE);
  assign error    = err_q;
  assign err_idx  = eidx_q;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      ph_q     <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      sr_q     <= '0;
      idx_q    <= '0;
      retry_q  <= '0;
      nack_q   <= 1'b0;
      err_q    <= 1'b0;
      eidx_q   <= '0;
      ld_q     <= 1'b0;
      scl_q    <= 1'b0;
      sda_q    <= 1'b0;
      int_s1_q <= 1'b1;
      int_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      nack_q   <= nack_d;
      err_q    <= err_d;
      eidx_q   <= eidx_d;
      ld_q     <= ld_d;
      scl_q    <= scl_d;
      sda_q    <= sda_d;
      int_s1_q <= int_n;
      int_s2_q <= int_s1_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    ph_d    = ph_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    nack_d  = nack_q;
    err_d   = err_q;
    eidx_d  = eidx_q;
    ld_d    = ld_q;
    scl_d   = 1'b0;
    sda_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idx_d   = '0;
        retry_d = '0;
        state_d = S_LOAD;
      end
      // ROM is synchronous: address set on entry, data valid next cycle.
      // Divider is cleared so the first bus phase is a full tick.
      S_LOAD: begin
        div_d = '0;
        ph_d  = '0;
        ld_d  = 1'b1;
        if (ld_q) begin
          ld_d    = 1'b0;
          sr_d    = {DEV_ADDR, tbl_data};
          bit_d   = '0;
          byte_d  = '0;
          nack_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        sda_d = (ph_q != 2'd0);
        scl_d = (ph_q == 2'd3);
        if (tick) begin
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd3) state_d = S_SHIFT;
        end
      end
      // Phase 0 holds SDA while SCL falls; data changes in phase 1.
      S_SHIFT: begin
        scl_d = ~ph_q[1];
        sda_d = (ph_q == 2'd0) ? sda_q : ~sr_q[23];
        if (tick) begin
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd3) begin
            sr_d  = {sr_q[22:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        scl_d = ~ph_q[1];
        sda_d = (ph_q == 2'd0) ? sda_q : 1'b0;
        if (tick) begin
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd2) nack_d = sda_s2_q;
          if (ph_q == 2'd3) begin
            if (nack_q || byte_q == 2'd2) begin
              state_d = S_STOP;
            end else begin
              byte_d  = byte_q + 2'd1;
              state_d = S_SHIFT;
            end
          end
        end
      end
      S_STOP: begin
        scl_d = ~ph_q[1];
        sda_d = (ph_q == 2'd0) ? sda_q : (ph_q != 2'd3);
        if (tick) begin
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd3) begin
            state_d = S_NEXT;
            if (nack_q) begin
              if (retry_q != RW'(MAX_RETRY)) begin
                retry_d = retry_q + RW'(1);
                state_d = S_LOAD;
              end else begin
                err_d = 1'b1;
                if (!err_q) eidx_d = idx_q;
              end
            end
          end
        end
      end
      S_NEXT: begin
        retry_d = '0;
        if (idx_q == TBL_AW'(TBL_DEPTH - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + TBL_AW'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        if (restart) begin
          err_d   = 1'b0;
          eidx_d  = '0;
          idx_d   = '0;
          retry_d = '0;
          state_d = S_LOAD;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_reg_table_cfg.sv
// Directed bench for i2c_reg_table_cfg with a cycle-sampled I2C slave
// model, a 64-entry ROM model and a frame log.
module tb_i2c_reg_table_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic        start = 1'b0;
  logic        int_n = 1'b1;
  logic        scl_oe, sda_oe;
  logic        busy, ready, error;
  logic [5:0]  err_idx;
  logic        slv_drv = 1'b0;
  wire         scl = ~scl_oe;
  wire         sda = ~(sda_oe | slv_drv);

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2c_reg_table_cfg #(
    .CLK_FREQ(8000000), .I2C_FREQ(1000000), .DEV_ADDR(8'h72),
    .TBL_DEPTH(31), .TBL_AW(6), .MAX_RETRY(3), .REINIT_ON_INT(1)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .start(start), .int_n(int_n),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda),
    .busy(busy), .ready(ready), .error(error), .err_idx(err_idx)
  );

  function automatic logic [15:0] rom_f(input int i);
    logic [7:0] s, d;
    s = 8'h10 + 8'(i);
    d = 8'(i * 37 + 5);
    return {s, d};
  endfunction

  always @(posedge clk) tbl_data <= rom_f(int'(tbl_addr));

  // Slave model
  logic        p_scl = 1'b1, p_sda = 1'b1;
  logic        in_fr = 1'b0, ack_slot = 1'b0;
  int          bitc = 0, bytc = 0;
  logic [7:0]  sh = '0;
  logic [7:0]  rx [3];
  logic [7:0]  nack_sub = 8'hFF;
  int          nack_limit = 0;
  logic [7:0]  last_sub = 8'hFF;
  int          nack_cnt = 0;
  logic [23:0] fr_data [512];
  int          fr_n [512];
  int          nfr = 0;

  always @(posedge clk) begin
    logic cs, cd, nak;
    cs = scl;
    cd = sda;
    if (nack_sub != last_sub) begin
      nack_cnt = 0;
      last_sub = nack_sub;
    end
    if (cs && p_scl && p_sda && !cd) begin
      in_fr = 1'b1; bitc = 0; bytc = 0;
      ack_slot = 1'b0; slv_drv = 1'b0;
    end else if (cs && p_scl && !p_sda && cd) begin
      if (in_fr && nfr < 512) begin
        fr_data[nfr] = {rx[0], rx[1], rx[2]};
        fr_n[nfr] = bytc;
        nfr++;
      end
      in_fr = 1'b0;
    end else if (!p_scl && cs && in_fr && !ack_slot) begin
      sh = {sh[6:0], cd};
      bitc++;
    end else if (p_scl && !cs && in_fr) begin
      if (ack_slot) begin
        slv_drv = 1'b0;
        ack_slot = 1'b0;
      end else if (bitc == 8) begin
        bitc = 0;
        if (bytc < 3) rx[bytc] = sh;
        nak = (bytc == 0 && sh != 8'h72) ||
              (bytc == 2 && rx[1] == nack_sub && nack_cnt < nack_limit);
        if (nak && bytc == 2) nack_cnt++;
        slv_drv = !nak;
        ack_slot = 1'b1;
        bytc++;
      end
    end
    p_scl = cs;
    p_sda = cd;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 12000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic wait_addr(input int a, input string tag);
    int n = 0;
    while (int'(tbl_addr) != a && n < 12000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_addr_reached"}, 32'(tbl_addr), 32'(a));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expected: every entry once, entry rep_idx repeated reps times.
  task automatic check_table(input int base, input string tag,
                             input int rep_idx, input int reps);
    int j = base;
    int total = 31 + ((rep_idx >= 0) ? reps - 1 : 0);
    logic [31:0] obs, exp;
    chk({tag, "_frames"}, 32'(nfr - base), 32'(total));
    for (int i = 0; i < 31; i++) begin
      int cnt = (i == rep_idx) ? reps : 1;
      for (int k = 0; k < cnt; k++) begin
        exp = {8'd3, 8'h72, rom_f(i)};
        obs = (j < nfr) ? {8'(fr_n[j]), fr_data[j]} : 32'd0;
        chk($sformatf("%s_frame%0d", tag, j - base), obs, exp);
        j++;
      end
    end
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", 32'(scl_oe), 32'd0);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_idx", 32'(err_idx), 32'd0);
    chk("rst_tbl_addr", 32'(tbl_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("busy_after_release", 32'(busy), 32'd1);

    // Full walk, all ACKed
    wait_ready("t1");
    check_table(0, "t1", -1, 1);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // Entry 5 NACKed twice, restart via start in DONE
    nack_sub = 8'h15;
    nack_limit = 2;
    base = nfr;
    pulse_start();
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_ready_low", 32'(ready), 32'd0);
    wait_ready("t2");
    check_table(base, "t2", 5, 3);
    chk("t2_error", 32'(error), 32'd0);

    // Entry 7 always NACKed; mid-table start ignored
    nack_sub = 8'h17;
    nack_limit = 1000;
    base = nfr;
    pulse_start();
    wait_addr(15, "t3");
    pulse_start();
    wait_ready("t3");
    check_table(base, "t3", 7, 4);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_err_idx", 32'(err_idx), 32'd7);
    repeat (400) @(negedge clk);
    chk("t3_no_queued_start", 32'(nfr - base), 32'd34);
    chk("t3_ready_held", 32'(ready), 32'd1);

    // int_n low for 80 cycles (10 us at 8 MHz) restarts once
    nack_sub = 8'hEE;
    base = nfr;
    @(negedge clk);
    int_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_ready_drop", 32'(ready), 32'd0);
    chk("t4_error_clr", 32'(error), 32'd0);
    chk("t4_err_idx_clr", 32'(err_idx), 32'd0);
    repeat (77) @(negedge clk);
    int_n = 1'b1;
    wait_ready("t4");
    check_table(base, "t4", -1, 1);
    chk("t4_error", 32'(error), 32'd0);
    repeat (400) @(negedge clk);
    chk("t4_single_restart", 32'(nfr - base), 32'd31);

    // Reset during the sub-address byte of entry 12
    pulse_start();
    wait_addr(12, "t5");
    begin
      int n = 0;
      while (!(in_fr && bytc == 1 && bitc == 3) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("t5_in_byte2", 32'(bytc), 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_scl_released", 32'(scl_oe), 32'd0);
    chk("t5_sda_released", 32'(sda_oe), 32'd0);
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_addr_rst", 32'(tbl_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = nfr;
    wait_ready("t5");
    check_table(base, "t5", -1, 1);
    chk("t5_error", 32'(error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
